// File: rtl/dsi_pkg.sv
// Shared DSI definitions: data-type codes, CRC constants, FSM state encoding and
// the 6-bit Hamming ECC over a 24-bit packet header.
package dsi_pkg;

   localparam logic [5:0] DCS_SHORT_W0 = 6'h05;
   localparam logic [5:0] DCS_SHORT_W1 = 6'h15;
   localparam logic [5:0] GEN_SHORT_W0 = 6'h03;
   localparam logic [5:0] GEN_SHORT_W1 = 6'h13;
   localparam logic [5:0] GEN_SHORT_W2 = 6'h23;
   localparam logic [5:0] DCS_LONG_W   = 6'h39;
   localparam logic [5:0] GEN_LONG_W   = 6'h29;

   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h8408;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR1,
      S_HDR2,
      S_ECC,
      S_PAYLOAD,
      S_CRC_L,
      S_CRC_H,
      S_DRAIN,
      S_GAP
   } pkt_state_e;

   function automatic logic is_long_dt(input logic [5:0] dt);
      return dt[3];
   endfunction

   // d = {wc[15:8], wc[7:0], DI}; d[0] is DI bit 0
   function automatic logic [5:0] dsi_ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^ d[11] ^
             d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^ d[12] ^
             d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^ d[12] ^
             d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
      p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^ d[14] ^
             d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
      p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^ d[17] ^
             d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
      p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
             d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
      return p;
   endfunction

endpackage

// File: rtl/dsi_crc16.sv
// Byte-wise CRC-16 (reflected 0x8408, LSB first) next-state; purely combinational.
// No latency, no handshake: the caller decides when to register crc_o.
module dsi_crc16
   import dsi_pkg::*;
(
   input  logic [15:0] crc_i,
   input  logic [7:0]  byte_i,
   output logic [15:0] crc_o
);

   always_comb begin
      logic [15:0] c;
      c = crc_i;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ byte_i[i]) begin
            c = (c >> 1) ^ CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      crc_o = c;
   end

endmodule

// File: rtl/dsi_lp_pkt_gen.sv
// DSI LPDT packet assembler: header, ECC, payload, CRC16 streamed one byte per tx handshake.
// First byte is presented the cycle after cmd accept; stalls on lpdt_tx_rdy, then holds an idle gap.
module dsi_lp_pkt_gen
   import dsi_pkg::*;
#(
   parameter int GAP_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_vld,
   output logic        cmd_rdy,
   input  logic [1:0]  cmd_vc,
   input  logic [5:0]  cmd_dt,
   input  logic [15:0] cmd_wc,
   input  logic        pl_vld,
   input  logic [7:0]  pl_data,
   output logic        pl_rdy,
   output logic        lpdt_tx_vld,
   output logic [7:0]  lpdt_tx_data,
   input  logic        lpdt_tx_rdy,
   input  logic        lpdt_tx_done,
   output logic        busy,
   output logic        pkt_done,
   output logic        underrun
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   pkt_state_e     state_q;
   logic [1:0]     vc_q;
   logic [5:0]     dt_q;
   logic [15:0]    wc_q;
   logic [5:0]     ecc_q;
   logic [15:0]    cnt_q;
   logic [15:0]    crc_q;
   logic [15:0]    crc_d;
   logic [GW-1:0]  gap_q;
   logic           vld_q;
   logic [7:0]     data_q;
   logic           cmd_rdy_q;
   logic           busy_q;
   logic           pkt_done_q;
   logic           underrun_q;

   logic           hs;
   logic           need_pl;
   logic [7:0]     pl_byte;

   assign hs      = lpdt_tx_rdy && vld_q;
   assign need_pl = (state_q == S_PAYLOAD) && (cnt_q != 16'd0);
   // A missing payload byte is replaced by zero so the packet length never changes
   assign pl_byte = pl_vld ? pl_data : 8'h00;

   dsi_crc16 u_crc (
      .crc_i  (crc_q),
      .byte_i (pl_byte),
      .crc_o  (crc_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         vc_q       <= '0;
         dt_q       <= '0;
         wc_q       <= '0;
         ecc_q      <= '0;
         cnt_q      <= '0;
         crc_q      <= CRC_INIT;
         gap_q      <= '0;
         vld_q      <= 1'b0;
         data_q     <= 8'h00;
         cmd_rdy_q  <= 1'b1;
         busy_q     <= 1'b0;
         pkt_done_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         pkt_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_vld && cmd_rdy_q) begin
                  vc_q       <= cmd_vc;
                  dt_q       <= cmd_dt;
                  wc_q       <= cmd_wc;
                  ecc_q      <= dsi_ecc({cmd_wc, cmd_vc, cmd_dt});
                  crc_q      <= CRC_INIT;
                  underrun_q <= 1'b0;
                  data_q     <= {cmd_vc, cmd_dt};
                  vld_q      <= 1'b1;
                  cmd_rdy_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_HDR1;
               end
            end
            S_HDR1: begin
               if (hs) begin
                  data_q  <= wc_q[7:0];
                  state_q <= S_HDR2;
               end
            end
            S_HDR2: begin
               if (hs) begin
                  data_q  <= wc_q[15:8];
                  state_q <= S_ECC;
               end
            end
            S_ECC: begin
               if (hs) begin
                  data_q <= {2'b00, ecc_q};
                  if (!is_long_dt(dt_q)) begin
                     state_q <= S_DRAIN;
                  end else if (wc_q == 16'd0) begin
                     state_q <= S_CRC_L;
                  end else begin
                     cnt_q   <= wc_q;
                     state_q <= S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (hs) begin
                  if (need_pl) begin
                     data_q <= pl_byte;
                     crc_q  <= crc_d;
                     cnt_q  <= cnt_q - 16'd1;
                     if (!pl_vld) begin
                        underrun_q <= 1'b1;
                     end
                  end else begin
                     data_q  <= crc_q[7:0];
                     state_q <= S_CRC_H;
                  end
               end
            end
            S_CRC_L: begin
               if (hs) begin
                  data_q  <= crc_q[7:0];
                  state_q <= S_CRC_H;
               end
            end
            S_CRC_H: begin
               if (hs) begin
                  data_q  <= crc_q[15:8];
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Dropping vld after the final byte is what tells the transmitter to close the packet
               if (hs) begin
                  vld_q <= 1'b0;
               end else if (!vld_q && lpdt_tx_done) begin
                  pkt_done_q <= 1'b1;
                  gap_q      <= GW'(GAP_CYCLES - 1);
                  state_q    <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_q == '0) begin
                  cmd_rdy_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               vld_q     <= 1'b0;
               cmd_rdy_q <= 1'b1;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_rdy      = cmd_rdy_q;
   assign pl_rdy       = hs && need_pl;
   assign lpdt_tx_vld  = vld_q;
   assign lpdt_tx_data = data_q;
   assign busy         = busy_q;
   assign pkt_done     = pkt_done_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_dsi_lp_pkt_gen.sv
// Bench for dsi_lp_pkt_gen: random-stall transmitter model, payload source and
// a byte scoreboard filled from an independent ECC/CRC reference.
module tb_dsi_lp_pkt_gen;
   import dsi_pkg::*;

   localparam int GAP = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic [1:0]  cmd_vc;
   logic [5:0]  cmd_dt;
   logic [15:0] cmd_wc;
   logic        pl_vld;
   logic [7:0]  pl_data;
   logic        pl_rdy;
   logic        lpdt_tx_vld;
   logic [7:0]  lpdt_tx_data;
   logic        lpdt_tx_rdy;
   logic        lpdt_tx_done;
   logic        busy;
   logic        pkt_done;
   logic        underrun;

   dsi_lp_pkt_gen #(.GAP_CYCLES(GAP)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_vld      (cmd_vld),
      .cmd_rdy      (cmd_rdy),
      .cmd_vc       (cmd_vc),
      .cmd_dt       (cmd_dt),
      .cmd_wc       (cmd_wc),
      .pl_vld       (pl_vld),
      .pl_data      (pl_data),
      .pl_rdy       (pl_rdy),
      .lpdt_tx_vld  (lpdt_tx_vld),
      .lpdt_tx_data (lpdt_tx_data),
      .lpdt_tx_rdy  (lpdt_tx_rdy),
      .lpdt_tx_done (lpdt_tx_done),
      .busy         (busy),
      .pkt_done     (pkt_done),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] pl_mem [0:15];
   int pl_len = 0;
   int pl_idx = 0;
   int hole   = -1;
   bit pl_take = 0;
   int rdy_mode = 0;
   int done_timer = 0;
   int cyc = 0;
   int last_hs_cyc = 0;
   int vld_fall_cyc = 0;
   int done_cyc = 0;
   int pkt_done_cyc = 0;
   int accept_cyc = 0;
   int accept_n = 0;
   int pl_pulses = 0;
   bit pkt_flag = 0;
   bit prev_vld = 0;

   // Syndrome column per header bit: which parity bits that data bit feeds
   logic [5:0] ecc_col [0:23] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

   function automatic logic [5:0] ref_ecc(input logic [23:0] d);
      logic [5:0] e;
      e = 6'h00;
      for (int i = 0; i < 24; i++) if (d[i]) e = e ^ ecc_col[i];
      return e;
   endfunction

   function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [7:0] b);
      logic [7:0] x;
      x = b ^ crc[7:0];
      x = x ^ {x[3:0], 4'h0};
      return (crc >> 8) ^ {x, 8'h00} ^ {5'b0, x, 3'b0} ^ {12'h000, x[7:4]};
   endfunction

   task automatic build_exp(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
      logic [7:0]  di;
      logic [7:0]  b;
      logic [15:0] crc;
      di = {vc, dt};
      exp_q.push_back(di);
      exp_q.push_back(wc[7:0]);
      exp_q.push_back(wc[15:8]);
      exp_q.push_back({2'b00, ref_ecc({wc, di})});
      if (dt[3]) begin
         crc = 16'hFFFF;
         for (int i = 0; i < int'(wc); i++) begin
            b = (i == hole) ? 8'h00 : pl_mem[i];
            exp_q.push_back(b);
            crc = ref_crc(crc, b);
         end
         exp_q.push_back(crc[7:0]);
         exp_q.push_back(crc[15:8]);
      end
   endtask

   task automatic setup_pl(input int len, input int hole_at);
      pl_len  = len;
      pl_idx  = 0;
      hole    = hole_at;
      pl_take = 0;
      got_q.delete();
      exp_q.delete();
      pl_pulses = 0;
      pkt_flag  = 0;
   endtask

   task automatic issue(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
      int t;
      t = 0;
      @(posedge clk); #1;
      cmd_vc = vc; cmd_dt = dt; cmd_wc = wc; cmd_vld = 1'b1;
      @(negedge clk);
      while (!cmd_rdy && t < 1000) begin @(negedge clk); t++; end
      if (t >= 1000) begin
         n_tests++; n_fail++;
         $display("FAIL issue_timeout: cmd_rdy still %b after %0d cycles, required 1", cmd_rdy, t);
      end
      @(posedge clk); #1;
      cmd_vld = 1'b0;
   endtask

   task automatic wait_pkt(input string name);
      int t;
      t = 0;
      while (!pkt_flag && t < 3000) begin @(negedge clk); t++; end
      if (!pkt_flag) begin
         n_tests++; n_fail++;
         $display("FAIL %s_pkt_done_timeout: no pkt_done in %0d cycles", name, t);
      end
      repeat (2) @(negedge clk);
   endtask

   // Transmitter and payload-source model, updated just after each rising edge
   initial begin
      lpdt_tx_rdy = 1'b0; lpdt_tx_done = 1'b0; pl_vld = 1'b0; pl_data = 8'h00;
      forever begin
         @(posedge clk); #1;
         lpdt_tx_done = (done_timer == 1);
         if (done_timer > 0) done_timer--;
         if (rdy_mode == 0) lpdt_tx_rdy = ($urandom_range(0, 3) != 0);
         if (pl_take) begin pl_idx++; pl_take = 0; end
         pl_vld  = (pl_idx < pl_len) && (pl_idx != hole);
         pl_data = pl_vld ? pl_mem[pl_idx] : 8'hEE;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (lpdt_tx_vld && lpdt_tx_rdy) begin
         got_q.push_back(lpdt_tx_data);
         last_hs_cyc = cyc;
      end
      if (pl_rdy) begin pl_pulses++; pl_take = 1; end
      if (prev_vld && !lpdt_tx_vld) begin done_timer = 3; vld_fall_cyc = cyc; end
      if (lpdt_tx_done) done_cyc = cyc;
      if (pkt_done) begin pkt_done_cyc = cyc; pkt_flag = 1; end
      if (cmd_vld && cmd_rdy) begin accept_cyc = cyc; accept_n++; end
      prev_vld = lpdt_tx_vld;
   end

   task automatic test_reset();
      rst = 1'b1; cmd_vld = 1'b0; cmd_vc = '0; cmd_dt = '0; cmd_wc = '0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({cmd_rdy, lpdt_tx_vld, busy, pkt_done, underrun, pl_rdy} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_flags: {rdy,vld,busy,done,und,pl_rdy}=%b, required 100000",
                  {cmd_rdy, lpdt_tx_vld, busy, pkt_done, underrun, pl_rdy});
      end
      n_tests++;
      if (lpdt_tx_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_data: got %02h, required 00", lpdt_tx_data);
      end
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_short_dcs(input string name, input logic [15:0] wc, input logic [7:0] ecc_k);
      logic [7:0] snap[$];
      logic [7:0] e, g;
      int i;
      setup_pl(0, -1);
      build_exp(2'd0, DCS_SHORT_W0, wc);
      issue(2'd0, DCS_SHORT_W0, wc);
      wait_pkt(name);
      snap = got_q;
      n_tests++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL %s_len: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
      end
      i = 0;
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, g, e); end
         i++;
      end
      n_tests++;
      if (snap.size() < 4 || snap[3] !== ecc_k) begin
         n_fail++; $display("FAIL %s_ecc_const: got %02h, required %02h", name, (snap.size() > 3) ? snap[3] : 8'hxx, ecc_k);
      end
      n_tests++;
      if (vld_fall_cyc - last_hs_cyc != 1) begin
         n_fail++; $display("FAIL %s_vld_fall: %0d cycles after last hs, required 1", name, vld_fall_cyc - last_hs_cyc);
      end
      n_tests++;
      if (pkt_done_cyc - done_cyc != 1) begin
         n_fail++; $display("FAIL %s_pkt_done_lat: %0d cycles after tx_done, required 1", name, pkt_done_cyc - done_cyc);
      end
      n_tests++;
      if (pl_pulses != 0) begin
         n_fail++; $display("FAIL %s_pl_rdy: %0d pulses, required 0", name, pl_pulses);
      end
   endtask

   task automatic test_long();
      logic [7:0] snap[$];
      logic [7:0] e, g;
      int i;
      setup_pl(9, -1);
      for (int k = 0; k < 9; k++) pl_mem[k] = 8'h31 + 8'(k);
      build_exp(2'd0, DCS_LONG_W, 16'd9);
      issue(2'd0, DCS_LONG_W, 16'd9);
      wait_pkt("long");
      snap = got_q;
      n_tests++;
      if (got_q.size() != 15) begin
         n_fail++; $display("FAIL long_len: got %0d bytes, required 15", got_q.size());
      end
      i = 0;
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL long_byte%0d: got %02h, required %02h", i, g, e); end
         i++;
      end
      n_tests++;
      if (snap.size() != 15 || {snap[14], snap[13]} !== 16'h6F91) begin
         n_fail++; $display("FAIL long_crc_const: got %02h%02h, required 6F91",
                            (snap.size() == 15) ? snap[14] : 8'hxx, (snap.size() == 15) ? snap[13] : 8'hxx);
      end
      n_tests++;
      if (pl_pulses != 9) begin n_fail++; $display("FAIL long_pl_rdy: %0d pulses, required 9", pl_pulses); end
      n_tests++;
      if (underrun !== 1'b0) begin n_fail++; $display("FAIL long_underrun: got %b, required 0", underrun); end
   endtask

   task automatic test_long_wc0();
      logic [7:0] e, g;
      int i;
      setup_pl(0, -1);
      build_exp(2'd0, DCS_LONG_W, 16'd0);
      issue(2'd0, DCS_LONG_W, 16'd0);
      wait_pkt("wc0");
      n_tests++;
      if (got_q.size() != 6) begin n_fail++; $display("FAIL wc0_len: got %0d bytes, required 6", got_q.size()); end
      n_tests++;
      if (got_q.size() == 6 && {got_q[3], got_q[4], got_q[5]} !== 24'h0FFFFF) begin
         n_fail++; $display("FAIL wc0_tail: got %02h %02h %02h, required 0F FF FF", got_q[3], got_q[4], got_q[5]);
      end
      i = 0;
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL wc0_byte%0d: got %02h, required %02h", i, g, e); end
         i++;
      end
      n_tests++;
      if (pl_pulses != 0) begin n_fail++; $display("FAIL wc0_pl_rdy: %0d pulses, required 0", pl_pulses); end
   endtask

   task automatic test_underrun();
      logic [7:0] e, g;
      int i;
      setup_pl(5, 2);
      for (int k = 0; k < 5; k++) pl_mem[k] = 8'hA0 + 8'(k);
      build_exp(2'd1, DCS_LONG_W, 16'd5);
      issue(2'd1, DCS_LONG_W, 16'd5);
      wait_pkt("underrun");
      n_tests++;
      if (got_q.size() != 11) begin n_fail++; $display("FAIL underrun_len: got %0d bytes, required 11", got_q.size()); end
      n_tests++;
      if (got_q.size() == 11 && got_q[6] !== 8'h00) begin
         n_fail++; $display("FAIL underrun_subst: got %02h, required 00", got_q[6]);
      end
      i = 0;
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL underrun_byte%0d: got %02h, required %02h", i, g, e); end
         i++;
      end
      n_tests++;
      if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag: got %b, required 1", underrun); end
   endtask

   task automatic test_generic();
      logic [5:0]  dts [0:3] = '{GEN_SHORT_W0, GEN_SHORT_W1, GEN_SHORT_W2, GEN_LONG_W};
      logic [15:0] wcs [0:3] = '{16'h0000, 16'h00A5, 16'h5A3C, 16'h0003};
      logic [7:0] e, g;
      for (int p = 0; p < 4; p++) begin
         setup_pl(3, -1);
         pl_mem[0] = 8'hC1; pl_mem[1] = 8'h7E; pl_mem[2] = 8'h00;
         build_exp(2'(p), dts[p], wcs[p]);
         issue(2'(p), dts[p], wcs[p]);
         wait_pkt("generic");
         n_tests++;
         if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL generic%0d_len: got %0d bytes, required %0d", p, got_q.size(), exp_q.size());
         end
         while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL generic%0d_byte: got %02h, required %02h", p, g, e); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e, g;
      int n0, t, a2, p1;
      setup_pl(0, -1);
      build_exp(2'd3, DCS_SHORT_W1, 16'h0136);
      build_exp(2'd3, DCS_SHORT_W1, 16'h0136);
      n0 = accept_n;
      @(posedge clk); #1;
      cmd_vc = 2'd3; cmd_dt = DCS_SHORT_W1; cmd_wc = 16'h0136; cmd_vld = 1'b1;
      t = 0;
      while (accept_n < n0 + 1 && t < 1000) begin @(negedge clk); t++; end
      @(negedge clk);
      n_tests++;
      if (underrun !== 1'b0) begin n_fail++; $display("FAIL b2b_underrun_clear: got %b, required 0", underrun); end
      t = 0;
      while (accept_n < n0 + 2 && t < 3000) begin @(negedge clk); t++; end
      a2 = accept_cyc; p1 = pkt_done_cyc;
      @(posedge clk); #1; cmd_vld = 1'b0;
      n_tests++;
      if (accept_n != n0 + 2) begin
         n_fail++; $display("FAIL b2b_accepts: got %0d accepts, required 2", accept_n - n0);
      end
      n_tests++;
      if (a2 - p1 != GAP) begin
         n_fail++; $display("FAIL b2b_gap: accept %0d cycles after pkt_done, required %0d", a2 - p1, GAP);
      end
      pkt_flag = 0;
      wait_pkt("b2b");
      n_tests++;
      if (got_q.size() != 8) begin n_fail++; $display("FAIL b2b_len: got %0d bytes, required 8", got_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL b2b_byte: got %02h, required %02h", g, e); end
      end
   endtask

   task automatic test_reset_mid();
      setup_pl(0, -1);
      @(negedge clk);
      rdy_mode = 1; lpdt_tx_rdy = 1'b0;
      issue(2'd0, DCS_SHORT_W0, 16'h0011);
      @(posedge clk); #1; lpdt_tx_rdy = 1'b1;
      @(posedge clk); #1; lpdt_tx_rdy = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({lpdt_tx_vld, busy, cmd_rdy} !== 3'b110 || lpdt_tx_data !== 8'h11) begin
         n_fail++; $display("FAIL midrst_hdr2: {vld,busy,rdy}=%b data=%02h, required 110 data=11",
                            {lpdt_tx_vld, busy, cmd_rdy}, lpdt_tx_data);
      end
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({lpdt_tx_vld, cmd_rdy, busy} !== 3'b010 || lpdt_tx_data !== 8'h00) begin
         n_fail++; $display("FAIL midrst_after: {vld,rdy,busy}=%b data=%02h, required 010 data=00",
                            {lpdt_tx_vld, cmd_rdy, busy}, lpdt_tx_data);
      end
      rdy_mode = 0;
      repeat (10) @(negedge clk);
      n_tests++;
      if ({busy, pkt_done, cmd_rdy} !== 3'b001) begin
         n_fail++; $display("FAIL midrst_stray_done: {busy,pkt_done,rdy}=%b, required 001", {busy, pkt_done, cmd_rdy});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_short_dcs("dcs11", 16'h0011, 8'h36);
      test_short_dcs("dcs29", 16'h0029, 8'h1C);
      test_long();
      test_long_wc0();
      test_underrun();
      test_back_to_back();
      test_generic();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dsi_lp_pkt_gen.md
Name: dsi_lp_pkt_gen

Overview:
- Packet assembler that sits directly upstream of the LPDT escape-mode byte transmitter on MIPI DSI data lane 0.
- Takes one command descriptor from the LCM init sequencer, plus a payload byte stream for long packets.
- Builds the complete DSI packet: header, ECC, payload, CRC16.
- Streams the packet byte by byte into the transmitter using its vld/rdy/done handshake, then enforces an LP-11 gap before accepting the next command.

Parameters:
- GAP_CYCLES, 16, clk cycles of idle (vld low) after the transmitter's done pulse before cmd_rdy re-asserts; minimum 1.

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- cmd_vld  in  1  command descriptor valid
- cmd_rdy  out  1  high in IDLE; descriptor accepted on cmd_vld&&cmd_rdy
- cmd_vc  in  2  virtual channel
- cmd_dt  in  6  data type; dt[3]=1 means long packet
- cmd_wc  in  16  long: payload byte count; short: {data1,data0}
- pl_vld  in  1  payload byte available
- pl_data  in  8  payload byte, valid with pl_vld
- pl_rdy  out  1  one-cycle pulse: pl_data consumed this cycle
- lpdt_tx_vld  out  1  to transmitter: held high for the whole packet
- lpdt_tx_data  out  8  to transmitter: current byte
- lpdt_tx_rdy  in  1  from transmitter: byte taken when lpdt_tx_rdy&&lpdt_tx_vld
- lpdt_tx_done  in  1  from transmitter: packet fully on the lane (1-cycle pulse)
- busy  out  1  high in any state other than IDLE
- pkt_done  out  1  1-cycle pulse on entry to GAP
- underrun  out  1  sticky; set when a payload byte is needed while pl_vld=0; cleared by rst or by the next cmd accept

Behaviour:
- Reset values: all outputs 0, except cmd_rdy=1. lpdt_tx_data=0, state=IDLE, CRC=16'hFFFF.
- Define handshake hs = lpdt_tx_rdy && lpdt_tx_vld. All byte advances happen on hs.
- States: IDLE, HDR1, HDR2, ECC, PAYLOAD, CRC_L, CRC_H, DRAIN, GAP.
- IDLE, on cmd accept:
  - Latch vc/dt/wc.
  - lpdt_tx_data <= DI = {vc,dt}, lpdt_tx_vld <= 1, go HDR1.
  - Compute ECC on the 24-bit header {wc[15:8], wc[7:0], DI} with the MIPI DSI 6-bit Hamming equations; ECC byte = {2'b00, p5..p0}.
- Byte sequence, one byte per hs; register lpdt_tx_data is loaded with the next byte in the same cycle as hs:
  - HDR1: next byte wc[7:0], go HDR2.
  - HDR2: next byte wc[15:8], go ECC.
  - ECC: next byte ECC, then:
    - short packet: go DRAIN;
    - long packet with wc=0: go CRC_L;
    - otherwise go PAYLOAD.
  - PAYLOAD:
    - On each hs that requires a payload byte: pl_rdy=1 (combinational, qualified by hs), lpdt_tx_data <= pl_data, CRC updated, byte counter decremented.
    - The first payload byte is loaded on the hs that accepts ECC.
    - When the counter reaches 0, the next hs loads crc[7:0] and goes CRC_H.
  - CRC_H: hs loads crc[15:8], go DRAIN.
- Last-byte rule: on the hs accepting the final byte (ECC for short packets, crc[15:8] for long), lpdt_tx_vld <= 0 in the next cycle. The transmitter uses vld low to terminate the packet.
- DRAIN: wait for lpdt_tx_done, then pkt_done pulse, go GAP.
- GAP: count GAP_CYCLES, then go IDLE with cmd_rdy=1.
- CRC: CRC-16, poly x^16+x^12+x^5+1 reflected (0x8408), init 0xFFFF, no final XOR, LSB-first per byte. Reset to 0xFFFF on cmd accept.
- Underrun: pl_vld=0 when a payload byte is required → substitute 0x00 (included in CRC), set underrun, continue. Packet length is never altered.
- lpdt_tx_rdy while lpdt_tx_vld=0 is ignored. lpdt_tx_done outside DRAIN is ignored.
- cmd_vld is ignored outside IDLE.
- rst mid-packet: return to reset values in one cycle. vld drops; the transmitter closes its escape sequence on its own.
- wc range: 0..65535 on the 16-bit counter, no wrap.

Decomposition:
- Package dsi_pkg:
  - DT constants: DCS_SHORT_W0=6'h05, DCS_SHORT_W1=6'h15, GEN_SHORT_W0/1/2=6'h03/13/23, DCS_LONG_W=6'h39, GEN_LONG_W=6'h29.
  - Function dsi_ecc(24-bit)→6-bit.
  - CRC init/poly constants.
- One sub-module dsi_crc16: byte-wise combinational next-CRC from (crc_in, byte).

Test Plan:
- Short DCS 0x11: vc=0, dt=0x05, wc=0x0011 → bytes 05,11,00,36 on successive hs; vld falls the cycle after the hs accepting 0x36; pkt_done one cycle after lpdt_tx_done.
- Short DCS 0x29: dt=0x05, wc=0x0029 → bytes 05,29,00,1C; no pl_rdy pulses.
- Long: dt=0x39, wc=9, payload ASCII "123456789" → header 39,09,00,ECC(ref model), 9 payload bytes, then 91,6F (CRC 0x6F91); exactly 9 pl_rdy pulses.
- Long wc=0: dt=0x39 → 39,00,00,ECC,FF,FF; zero pl_rdy pulses.
- Underrun: pl_vld forced low at payload byte 3 of 5 → 0x00 sent in its place, underrun=1, total byte count 11, CRC matches the substituted data.
- Back-to-back plus reset: cmd_vld held high → second cmd accepted exactly GAP_CYCLES after pkt_done; rst asserted at HDR2 → next cycle vld=0, cmd_rdy=1, busy=0.
